// File: rtl/cache_ctrl_fsm.sv
// rtl/cache_ctrl_fsm.sv - sequencing FSM for the direct-mapped cache: lookup, write-back, allocate, flush
module cache_ctrl_fsm #(
  parameter int  NUM_SETS    = 8,
  parameter int  ACK_TIMEOUT = 255,
  localparam int INDEX_WIDTH = $clog2(NUM_SETS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   CPU_request,
  input  logic                   read_req,
  input  logic                   write_req,
  input  logic [31:0]            address,
  input  logic                   Cache_flush,
  input  logic                   Cache_hit,
  input  logic                   line_valid,
  input  logic                   line_dirty,
  input  logic                   Main_mem_ack,
  output logic [INDEX_WIDTH-1:0] set_index,
  output logic                   cache_we,
  output logic                   cache_fill,
  output logic                   cache_inv,
  output logic                   mem_read_req,
  output logic                   mem_write_req,
  output logic                   cpu_ready,
  output logic                   cpu_error,
  output logic                   Flush_done,
  output logic                   busy
);
  localparam int                     WAIT_WIDTH = $clog2(ACK_TIMEOUT + 1);
  localparam logic [WAIT_WIDTH-1:0]  WAIT_LIMIT = WAIT_WIDTH'(ACK_TIMEOUT);
  localparam logic [INDEX_WIDTH-1:0] LAST_SET   = INDEX_WIDTH'(NUM_SETS - 1);

  typedef enum logic [2:0] {
    IDLE, COMPARE, WRITEBACK, ALLOCATE, FLUSH_CHK, FLUSH_WB, FLUSH_INV
  } state_t;

  state_t                 state, state_n;
  logic [INDEX_WIDTH-1:0] req_index;
  logic [INDEX_WIDTH-1:0] flush_cnt;
  logic                   op_write;
  logic [WAIT_WIDTH-1:0]  wait_cnt;
  logic                   cpu_accept;
  logic                   line_needs_wb;
  logic                   timed_out;
  logic                   waiting;
  logic                   flushing;
  logic                   unused_address;

  assign unused_address = ^{address[31:INDEX_WIDTH+2], address[1:0]};
  assign cpu_accept     = CPU_request && (read_req ^ write_req);
  assign line_needs_wb  = line_valid && line_dirty;
  assign timed_out      = (wait_cnt == WAIT_LIMIT);
  assign waiting        = (state == WRITEBACK) || (state == ALLOCATE) || (state == FLUSH_WB);
  assign flushing       = (state == FLUSH_CHK) || (state == FLUSH_WB) || (state == FLUSH_INV);
  assign busy           = (state != IDLE);
  assign set_index      = flushing ? flush_cnt : req_index;

  // Wait counter restarts whenever a wait state is entered or left.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      req_index <= '0;
      op_write  <= 1'b0;
      flush_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && !Cache_flush && cpu_accept) begin
        req_index <= address[INDEX_WIDTH+1:2];
        op_write  <= write_req;
      end
      if (state == IDLE)
        flush_cnt <= '0;
      else if (state == FLUSH_INV && state_n == FLUSH_CHK)
        flush_cnt <= flush_cnt + INDEX_WIDTH'(1);
      wait_cnt <= (waiting && state_n == state) ? wait_cnt + WAIT_WIDTH'(1) : '0;
    end
  end

  always_comb begin
    state_n       = state;
    cache_we      = 1'b0;
    cache_fill    = 1'b0;
    cache_inv     = 1'b0;
    mem_read_req  = 1'b0;
    mem_write_req = 1'b0;
    cpu_ready     = 1'b0;
    cpu_error     = 1'b0;
    Flush_done    = 1'b0;
    case (state)
      IDLE: begin
        if (Cache_flush)     state_n = FLUSH_CHK;
        else if (cpu_accept) state_n = COMPARE;
      end
      COMPARE: begin
        if (Cache_hit) begin
          cpu_ready = 1'b1;
          cache_we  = op_write;
          state_n   = IDLE;
        end else if (line_needs_wb) begin
          state_n = WRITEBACK;
        end else begin
          state_n = ALLOCATE;
        end
      end
      WRITEBACK: begin
        if (timed_out) begin
          cpu_ready = 1'b1;
          cpu_error = 1'b1;
          state_n   = IDLE;
        end else begin
          mem_write_req = 1'b1;
          if (Main_mem_ack) state_n = ALLOCATE;
        end
      end
      ALLOCATE: begin
        if (timed_out) begin
          cpu_ready = 1'b1;
          cpu_error = 1'b1;
          state_n   = IDLE;
        end else begin
          mem_read_req = 1'b1;
          if (Main_mem_ack) begin
            cache_fill = 1'b1;
            state_n    = COMPARE;
          end
        end
      end
      FLUSH_CHK: state_n = line_needs_wb ? FLUSH_WB : FLUSH_INV;
      FLUSH_WB: begin
        if (timed_out) begin
          Flush_done = 1'b1;
          cpu_error  = 1'b1;
          state_n    = IDLE;
        end else begin
          mem_write_req = 1'b1;
          if (Main_mem_ack) state_n = FLUSH_INV;
        end
      end
      FLUSH_INV: begin
        cache_inv = 1'b1;
        if (flush_cnt == LAST_SET) begin
          Flush_done = 1'b1;
          state_n    = IDLE;
        end else begin
          state_n = FLUSH_CHK;
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// tb/tb_cache_ctrl_fsm.sv - randomized self-checking bench for cache_ctrl_fsm
module tb_cache_ctrl_fsm;
  localparam int NS = 8;
  localparam int T  = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        CPU_request = 1'b0, read_req = 1'b0, write_req = 1'b0;
  logic [31:0] address = '0;
  logic        Cache_flush = 1'b0, Main_mem_ack = 1'b0;
  logic        Cache_hit, line_valid, line_dirty;
  logic [2:0]  set_index;
  logic        cache_we, cache_fill, cache_inv, mem_read_req, mem_write_req;
  logic        cpu_ready, cpu_error, Flush_done, busy;

  cache_ctrl_fsm #(.NUM_SETS(NS), .ACK_TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .CPU_request(CPU_request), .read_req(read_req),
    .write_req(write_req), .address(address), .Cache_flush(Cache_flush),
    .Cache_hit(Cache_hit), .line_valid(line_valid), .line_dirty(line_dirty),
    .Main_mem_ack(Main_mem_ack), .set_index(set_index), .cache_we(cache_we),
    .cache_fill(cache_fill), .cache_inv(cache_inv), .mem_read_req(mem_read_req),
    .mem_write_req(mem_write_req), .cpu_ready(cpu_ready), .cpu_error(cpu_error),
    .Flush_done(Flush_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Cache array as seen by the controller (env_*) and as the bench expects it (ref_*).
  logic        env_valid [NS];
  logic        env_dirty [NS];
  logic [26:0] env_tag   [NS];
  logic        ref_valid [NS];
  logic        ref_dirty [NS];
  logic [26:0] ref_tag   [NS];
  logic [26:0] cur_tag = '0;

  assign line_valid = env_valid[set_index];
  assign line_dirty = env_dirty[set_index];
  assign Cache_hit  = env_valid[set_index] && (env_tag[set_index] == cur_tag);

  int   n_checks = 0, n_fail = 0;
  int   n_ready, n_err, n_done, n_inv, n_rd, n_wr, n_wr_ph, n_both, n_we, n_fill, n_fill_bad;
  int   req_cyc = 0, wb_delay = 1, rd_delay = 1;
  bit   noise = 1'b0;
  logic wr_prev = 1'b0;
  logic pend_fill = 1'b0, pend_we = 1'b0, pend_inv = 1'b0;
  logic [2:0] pend_idx = '0;
  int   m_lat;
  logic m_err;
  logic [2:0] m_idx;
  int   e_lat, e_rd, e_wr, e_inv, e_ph;
  logic e_err;

  task automatic clear_counts();
    n_ready = 0; n_err = 0; n_done = 0; n_inv = 0; n_rd = 0; n_wr = 0; n_wr_ph = 0;
    n_both = 0; n_we = 0; n_fill = 0; n_fill_bad = 0;
  endtask

  // One clock: apply last cycle's array strobes, play memory, then sample mid-cycle.
  task automatic step();
    @(negedge clk);
    if (pend_fill) begin env_valid[pend_idx] = 1'b1; env_dirty[pend_idx] = 1'b0; env_tag[pend_idx] = cur_tag; end
    if (pend_we) env_dirty[pend_idx] = 1'b1;
    if (pend_inv) begin env_valid[pend_idx] = 1'b0; env_dirty[pend_idx] = 1'b0; end
    if (Main_mem_ack) req_cyc = 0;
    if (mem_read_req || mem_write_req) begin
      req_cyc++;
      Main_mem_ack = (req_cyc == (mem_write_req ? wb_delay : rd_delay));
    end else begin
      req_cyc = 0;
      Main_mem_ack = noise ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
    #1;
    if (cpu_ready) n_ready++;
    if (cpu_error) n_err++;
    if (Flush_done) n_done++;
    if (cache_inv) n_inv++;
    if (cache_we) n_we++;
    if (cache_fill) n_fill++;
    if (cache_fill && !Main_mem_ack) n_fill_bad++;
    if (mem_read_req) n_rd++;
    if (mem_write_req) begin n_wr++; if (!wr_prev) n_wr_ph++; end
    if (mem_read_req && mem_write_req) n_both++;
    wr_prev = mem_write_req;
    pend_fill = cache_fill; pend_we = cache_we; pend_inv = cache_inv; pend_idx = set_index;
  endtask

  task automatic preload(input int s, input logic v, input logic d, input logic [26:0] tg);
    env_valid[s] = v; env_dirty[s] = d; env_tag[s] = tg;
    ref_valid[s] = v; ref_dirty[s] = d; ref_tag[s] = tg;
  endtask

  function automatic bit arrays_match();
    for (int s = 0; s < NS; s++) begin
      if (env_valid[s] !== ref_valid[s]) return 1'b0;
      if (ref_valid[s] && (env_dirty[s] !== ref_dirty[s] || env_tag[s] !== ref_tag[s])) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Reference: cycle cost of one CPU op from the line's prior state and memory delays (0 or >T = no ack).
  task automatic ref_op(input logic [31:0] addr, input logic wr, input int dw, input int dr);
    int idx;
    logic [26:0] tg;
    idx = int'(addr[4:2]);
    tg  = addr[31:5];
    e_rd = 0; e_wr = 0; e_err = 1'b0; e_lat = 1;
    if (ref_valid[idx] && ref_tag[idx] == tg) begin
      if (wr) ref_dirty[idx] = 1'b1;
    end else begin
      if (ref_valid[idx] && ref_dirty[idx]) begin
        if (dw == 0 || dw > T) begin e_wr = T; e_lat += T + 1; e_err = 1'b1; end
        else begin e_wr = dw; e_lat += dw; end
      end
      if (!e_err) begin
        if (dr == 0 || dr > T) begin e_rd = T; e_lat += T + 1; e_err = 1'b1; end
        else begin
          e_rd = dr; e_lat += dr + 1;
          ref_valid[idx] = 1'b1; ref_tag[idx] = tg; ref_dirty[idx] = wr;
        end
      end
    end
  endtask

  task automatic ref_flush(input int dw);
    e_lat = 0; e_err = 1'b0; e_inv = 0; e_ph = 0;
    for (int s = 0; s < NS && !e_err; s++) begin
      e_lat++;
      if (ref_valid[s] && ref_dirty[s]) begin
        e_ph++;
        if (dw == 0 || dw > T) begin e_lat += T + 1; e_err = 1'b1; end
        else e_lat += dw;
      end
      if (!e_err) begin e_lat++; e_inv++; ref_valid[s] = 1'b0; ref_dirty[s] = 1'b0; end
    end
  endtask

  task automatic run_op(input logic [31:0] addr, input logic wr);
    cur_tag = addr[31:5]; address = addr; read_req = !wr; write_req = wr; CPU_request = 1'b1;
    step();
    CPU_request = 1'b0; read_req = 1'b0; write_req = 1'b0; address = $urandom;
    m_lat = -1; m_err = 1'b0; m_idx = '0;
    for (int c = 1; c <= 40 && m_lat < 0; c++) begin
      if (c > 1) step();
      if (cpu_ready) begin m_lat = c; m_err = cpu_error; m_idx = set_index; end
    end
    step();
  endtask

  task automatic run_flush();
    Cache_flush = 1'b1;
    step();
    m_lat = -1; m_err = 1'b0;
    for (int c = 1; c <= 300 && m_lat < 0; c++) begin
      if (c > 1) step();
      if (Flush_done) begin m_lat = c; m_err = cpu_error; Cache_flush = 1'b0; end
    end
    step();
  endtask

  task automatic test_reset();
    step(); step();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (set_index !== 3'd0) begin n_fail++; $display("FAIL reset_index: got %0d expected 0", set_index); end
    n_checks++; if ({cache_we, cache_fill, cache_inv, mem_read_req, mem_write_req, cpu_ready, cpu_error, Flush_done} !== 8'h00) begin
      n_fail++; $display("FAIL reset_strobes: got %b expected 00000000",
        {cache_we, cache_fill, cache_inv, mem_read_req, mem_write_req, cpu_ready, cpu_error, Flush_done}); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_read_hit();
    preload(4, 1'b1, 1'b0, 27'd0);
    ref_op(32'h10, 1'b0, 1, 1);
    clear_counts();
    run_op(32'h10, 1'b0);
    n_checks++; if (m_lat !== 1) begin n_fail++; $display("FAIL hit_latency: got %0d expected 1", m_lat); end
    n_checks++; if (m_idx !== 3'd4) begin n_fail++; $display("FAIL hit_index: got %0d expected 4", m_idx); end
    n_checks++; if (n_rd + n_wr !== 0) begin n_fail++; $display("FAIL hit_mem_cycles: got %0d expected 0", n_rd + n_wr); end
    n_checks++; if (n_ready !== 1) begin n_fail++; $display("FAIL hit_ready_pulses: got %0d expected 1", n_ready); end
  endtask

  task automatic test_clean_miss();
    preload(3, 1'b1, 1'b0, 27'd9);
    rd_delay = 3;
    ref_op(32'h0C, 1'b0, 1, 3);
    clear_counts();
    run_op(32'h0C, 1'b0);
    n_checks++; if (m_lat !== 5) begin n_fail++; $display("FAIL miss_latency: got %0d expected 5", m_lat); end
    n_checks++; if (n_rd !== 3) begin n_fail++; $display("FAIL miss_read_cycles: got %0d expected 3", n_rd); end
    n_checks++; if (n_fill !== 1 || n_fill_bad !== 0) begin n_fail++; $display("FAIL miss_fill: got %0d fills (%0d off-ack) expected 1 (0)", n_fill, n_fill_bad); end
    n_checks++; if (!arrays_match()) begin n_fail++; $display("FAIL miss_array: got 0 expected 1"); end
  endtask

  task automatic test_dirty_write_miss();
    preload(2, 1'b1, 1'b1, 27'd5);
    wb_delay = 2; rd_delay = 2;
    ref_op(32'h28, 1'b1, 2, 2);
    clear_counts();
    run_op(32'h28, 1'b1);
    n_checks++; if (m_lat !== 6) begin n_fail++; $display("FAIL dirty_latency: got %0d expected 6", m_lat); end
    n_checks++; if (n_wr !== 2 || n_rd !== 2) begin n_fail++; $display("FAIL dirty_mem_cycles: got wr=%0d rd=%0d expected 2 2", n_wr, n_rd); end
    n_checks++; if (n_we !== 1) begin n_fail++; $display("FAIL dirty_we: got %0d expected 1", n_we); end
    n_checks++; if (!arrays_match()) begin n_fail++; $display("FAIL dirty_array: got 0 expected 1"); end
  endtask

  task automatic test_flush();
    for (int s = 0; s < NS; s++) preload(s, 1'b1, (s == 1 || s == 6), 27'(s));
    wb_delay = 1;
    ref_flush(1);
    clear_counts();
    run_flush();
    n_checks++; if (m_lat !== 18) begin n_fail++; $display("FAIL flush_latency: got %0d expected 18", m_lat); end
    n_checks++; if (n_wr_ph !== 2) begin n_fail++; $display("FAIL flush_wb_phases: got %0d expected 2", n_wr_ph); end
    n_checks++; if (n_inv !== 8) begin n_fail++; $display("FAIL flush_inv: got %0d expected 8", n_inv); end
    n_checks++; if (n_done !== 1 || m_err !== 1'b0) begin n_fail++; $display("FAIL flush_done: got %0d err=%b expected 1 err=0", n_done, m_err); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy_after: got %b expected 0", busy); end
    n_checks++; if (!arrays_match()) begin n_fail++; $display("FAIL flush_array: got 0 expected 1"); end
  endtask

  task automatic test_timeout();
    preload(7, 1'b0, 1'b0, 27'd0);
    rd_delay = 0;
    ref_op(32'h1C, 1'b0, 1, 0);
    clear_counts();
    run_op(32'h1C, 1'b0);
    n_checks++; if (n_rd !== 4) begin n_fail++; $display("FAIL timeout_read_cycles: got %0d expected 4", n_rd); end
    n_checks++; if (m_lat !== 6 || m_err !== 1'b1) begin n_fail++; $display("FAIL timeout_ready: got lat=%0d err=%b expected 6 1", m_lat, m_err); end
    n_checks++; if (n_ready !== 1 || busy !== 1'b0) begin n_fail++; $display("FAIL timeout_idle: got ready=%0d busy=%b expected 1 0", n_ready, busy); end
    n_checks++; if (!arrays_match()) begin n_fail++; $display("FAIL timeout_array: got 0 expected 1"); end
  endtask

  task automatic test_reset_mid();
    preload(0, 1'b0, 1'b0, 27'd0);
    rd_delay = 0; cur_tag = '0; address = 32'h0; read_req = 1'b1; CPU_request = 1'b1;
    clear_counts();
    step();
    CPU_request = 1'b0; read_req = 1'b0;
    step(); step();
    n_checks++; if (mem_read_req !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_allocate: got %b expected 1", mem_read_req); end
    reset = 1'b0;
    step();
    n_checks++; if ({busy, cache_we, cache_fill, cache_inv, mem_read_req, mem_write_req, cpu_ready, cpu_error, Flush_done} !== 9'h000) begin
      n_fail++; $display("FAIL rstmid_outputs: got %b expected 000000000",
        {busy, cache_we, cache_fill, cache_inv, mem_read_req, mem_write_req, cpu_ready, cpu_error, Flush_done}); end
    n_checks++; if (set_index !== 3'd0 || n_ready !== 0) begin n_fail++; $display("FAIL rstmid_index_ready: got idx=%0d ready=%0d expected 0 0", set_index, n_ready); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_invalid_req();
    address = 32'h14; CPU_request = 1'b1; read_req = 1'b1; write_req = 1'b1;
    step();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL both_ops_ignored: got busy=%b expected 0", busy); end
    read_req = 1'b0; write_req = 1'b0;
    step();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL no_op_ignored: got busy=%b expected 0", busy); end
    CPU_request = 1'b0;
    step();
  endtask

  task automatic test_flush_priority();
    int fd, rc, exp_fd, exp_rc;
    for (int s = 0; s < NS; s++) preload(s, 1'b1, 1'b0, 27'd7);
    ref_flush(1);
    exp_fd = e_lat;
    ref_op(32'h14, 1'b0, 1, 2);
    exp_rc = exp_fd + 1 + e_lat;
    rd_delay = 2; cur_tag = '0; address = 32'h14; read_req = 1'b1; CPU_request = 1'b1; Cache_flush = 1'b1;
    clear_counts();
    fd = -1; rc = -1;
    for (int c = 1; c <= 60 && rc < 0; c++) begin
      step();
      if (cpu_ready) rc = c;
      if (Flush_done) begin fd = c; Cache_flush = 1'b0; end
      if (fd > 0 && c == fd + 2) begin CPU_request = 1'b0; read_req = 1'b0; end
    end
    step();
    n_checks++; if (fd !== exp_fd) begin n_fail++; $display("FAIL prio_flush_done: got %0d expected %0d", fd, exp_fd); end
    n_checks++; if (rc !== exp_rc) begin n_fail++; $display("FAIL prio_cpu_ready: got %0d expected %0d", rc, exp_rc); end
    n_checks++; if (n_ready !== 1 || n_done !== 1) begin n_fail++; $display("FAIL prio_pulses: got ready=%0d done=%0d expected 1 1", n_ready, n_done); end
    n_checks++; if (!arrays_match()) begin n_fail++; $display("FAIL prio_array: got 0 expected 1"); end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic        wr;
    int          dw, dr;
    for (int s = 0; s < NS; s++) begin
      wr = 1'($urandom_range(0, 1));
      preload(s, wr, wr & 1'($urandom_range(0, 1)), 27'($urandom_range(0, 2)));
    end
    noise = 1'b1;
    for (int it = 0; it < 40; it++) begin
      dw = $urandom_range(1, T + 1);
      if ($urandom_range(0, 5) == 0) begin
        ref_flush(dw);
        wb_delay = dw;
        clear_counts();
        run_flush();
        n_checks++; if (m_lat !== e_lat || m_err !== e_err) begin n_fail++; $display("FAIL rnd_flush_%0d: got lat=%0d err=%b expected %0d %b", it, m_lat, m_err, e_lat, e_err); end
        n_checks++; if (n_inv !== e_inv || n_wr_ph !== e_ph) begin n_fail++; $display("FAIL rnd_flush_ops_%0d: got inv=%0d wb=%0d expected %0d %0d", it, n_inv, n_wr_ph, e_inv, e_ph); end
      end else begin
        dr = $urandom_range(1, T + 1);
        wr = 1'($urandom_range(0, 1));
        a  = 32'(($urandom_range(0, 2) << 5) | ($urandom_range(0, NS - 1) << 2));
        ref_op(a, wr, dw, dr);
        wb_delay = dw; rd_delay = dr;
        clear_counts();
        run_op(a, wr);
        n_checks++; if (m_lat !== e_lat || m_err !== e_err) begin n_fail++; $display("FAIL rnd_op_%0d: got lat=%0d err=%b expected %0d %b", it, m_lat, m_err, e_lat, e_err); end
        n_checks++; if (m_idx !== a[4:2] || n_ready !== 1) begin n_fail++; $display("FAIL rnd_idx_%0d: got idx=%0d ready=%0d expected %0d 1", it, m_idx, n_ready, a[4:2]); end
        n_checks++; if (n_rd !== e_rd || n_wr !== e_wr) begin n_fail++; $display("FAIL rnd_mem_%0d: got rd=%0d wr=%0d expected %0d %0d", it, n_rd, n_wr, e_rd, e_wr); end
      end
      n_checks++; if (!arrays_match() || n_both !== 0) begin n_fail++; $display("FAIL rnd_array_%0d: got match=%0d both=%0d expected 1 0", it, arrays_match(), n_both); end
    end
    noise = 1'b0;
  endtask

  initial begin
    for (int s = 0; s < NS; s++) preload(s, 1'b0, 1'b0, 27'd0);
    test_reset();
    test_read_hit();
    test_clean_miss();
    test_dirty_write_miss();
    test_flush();
    test_timeout();
    test_reset_mid();
    test_invalid_req();
    test_flush_priority();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cache_ctrl_fsm.md
# cache_ctrl_fsm

Sequencing controller for the direct-mapped `cache_mem` datapath. It accepts one CPU read or write at a time, and runs the lookup → write-back → allocate → retry sequence on misses. It also walks every set to write back dirty lines and invalidate all lines on a flush command. It sits between the CPU request port, the cache array and the main-memory handshake, and it owns all memory request strobes.

## Interface
- NUM_SETS, 8, number of cache sets (power of 2); INDEX_WIDTH = $clog2(NUM_SETS)
- ACK_TIMEOUT, 255, maximum wait cycles for Main_mem_ack before aborting
- clk  in  1  single clock; all state changes on the rising edge
- reset  in  1  synchronous, active-low; sampled on the rising edge of clk
- CPU_request  in  1  CPU request valid (level)
- read_req / write_req  in  1 each  operation select; exactly one must be high with CPU_request
- address  in  32  CPU address; index = address[INDEX_WIDTH+1:2]
- Cache_flush  in  1  flush command (level, held until Flush_done)
- Cache_hit  in  1  tag match and valid for the line at set_index
- line_valid / line_dirty  in  1 each  valid and dirty bits of the line at set_index
- Main_mem_ack  in  1  memory completion for the current request
- set_index  out  INDEX_WIDTH  index presented to the cache: latched address index, or flush counter
- cache_we  out  1  write CPU data into the line (1-cycle pulse)
- cache_fill  out  1  load mem data into the line, clear dirty (1-cycle pulse)
- cache_inv  out  1  invalidate the line (1-cycle pulse)
- mem_read_req / mem_write_req  out  1 each  memory request, held until ack
- cpu_ready  out  1  CPU operation complete (1-cycle pulse)
- cpu_error  out  1  memory timeout; pulses together with cpu_ready or Flush_done
- Flush_done  out  1  flush complete (1-cycle pulse)
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, COMPARE, WRITEBACK, ALLOCATE, FLUSH_CHK, FLUSH_WB, FLUSH_INV.
- IDLE:
  - Cache_flush high → FLUSH_CHK with flush counter = 0. A flush has priority over a simultaneous CPU_request.
  - Otherwise, CPU_request && (read_req ^ write_req) → latch the index and the operation, then → COMPARE.
  - Requests with both or neither of read_req/write_req are ignored.
- COMPARE (one cycle):
  - On a hit, pulse cpu_ready, plus cache_we if the operation is a write, → IDLE.
  - On a miss with line_valid && line_dirty → WRITEBACK.
  - On any other miss → ALLOCATE.
- WRITEBACK: mem_write_req=1; on ack → ALLOCATE.
- ALLOCATE: mem_read_req=1; on ack, pulse cache_fill → COMPARE. The retry then hits, and a write retry merges the CPU data.
- FLUSH_CHK:
  - If line_valid && line_dirty → FLUSH_WB.
  - Otherwise → FLUSH_INV.
- FLUSH_WB: mem_write_req=1; on ack → FLUSH_INV.
- FLUSH_INV: pulse cache_inv.
  - If counter == NUM_SETS-1, pulse Flush_done → IDLE.
  - Otherwise, increment the counter → FLUSH_CHK.
- Wait counter: cleared on entry to each wait state and incremented each cycle without ack. Reaching ACK_TIMEOUT:
  - in a CPU operation: drop the request, pulse cpu_ready + cpu_error → IDLE;
  - in a flush: pulse Flush_done + cpu_error → IDLE. Any lines not yet processed are left untouched.
- Main_mem_ack is ignored outside WRITEBACK, ALLOCATE and FLUSH_WB.
- Cache_flush raised during a CPU operation stays pending. It is serviced on the next IDLE cycle.
- The latched index is held for the whole operation; address changes after acceptance are ignored.

## Timing
- Reset values: state IDLE, counters 0, set_index 0, busy 0. All strobes, cpu_ready, cpu_error and Flush_done are 0.
- Reset asserted mid-operation returns the block to IDLE at that edge. Requests drop in the following cycle, and no cpu_ready or Flush_done is issued.
- Strobe outputs are decoded from the state register and current inputs. The ack and the cache_fill pulse fall in the same cycle.
- Hit latency: request accepted at edge N; cpu_ready is high during cycle N+1.
- Clean-miss latency: COMPARE, then ALLOCATE for k cycles (ack in the k-th), then COMPARE. cpu_ready arrives k+2 cycles after acceptance.
- Dirty-miss latency adds the WRITEBACK wait cycles (j) to the clean-miss figure.
- Flush with no dirty lines: 2×NUM_SETS cycles after acceptance; Flush_done is high in the last of them.
- Only one of mem_read_req or mem_write_req is ever high. A new request can be accepted in the cycle after cpu_ready.

## Test plan
- Read hit: preload the line, hold CPU_request+read_req at 0x0000_0010 → set_index=4 and cpu_ready high for exactly one cycle, in the cycle after acceptance; no memory request.
- Clean read miss, ack 3 cycles after request: mem_read_req high 3 cycles, cache_fill pulses with the ack, cpu_ready 5 cycles after acceptance.
- Dirty write miss (line 2 valid+dirty, new tag): mem_write_req until ack, then mem_read_req until ack, then cache_we and cpu_ready in the retry COMPARE.
- Flush with sets 1 and 6 dirty, ack after 1 cycle: exactly two mem_write_req phases, eight cache_inv pulses, Flush_done once at the end; busy low afterwards.
- ACK_TIMEOUT=4, ack never arrives on a miss: mem_read_req drops after 4 cycles, cpu_ready and cpu_error pulse together, state IDLE.
- Reset low during ALLOCATE, plus Cache_flush and CPU_request raised in the same IDLE cycle: the reset case leaves all outputs 0 the cycle after reset; the simultaneous case starts the flush first and holds the CPU request off until Flush_done.
